// File: rtl/phys_reg_file_cdb.sv
// Physical register file and ready table fed by the N-lane common data bus.
// Operand reads bypass same-cycle CDB results; ready_vec is the raw registered table.

module phys_reg_file_cdb_rd_port #(
   parameter int N         = 3,
   parameter int PHYS_REGS = 64,
   parameter int DATA_W    = 32,
   parameter int IDX_W     = $clog2(PHYS_REGS)
) (
   input  logic [IDX_W-1:0]                  tag_i,
   input  logic [N-1:0][DATA_W-1:0]          cdb_res_i,
   input  logic [N-1:0][IDX_W-1:0]           cdb_tag_i,
   input  logic [N-1:0]                      cdb_vld_i,
   input  logic [PHYS_REGS-1:0][DATA_W-1:0]  data_i,
   input  logic [PHYS_REGS-1:0]              ready_i,
   output logic [DATA_W-1:0]                 data_o,
   output logic                              ready_o
);
   always_comb begin
      data_o  = data_i[tag_i];
      ready_o = ready_i[tag_i];
      // Ascending scan so the highest matching lane wins.
      for (int i = 0; i < N; i++) begin
         if (cdb_vld_i[i] && (cdb_tag_i[i] == tag_i) && (tag_i != '0)) begin
            data_o  = cdb_res_i[i];
            ready_o = 1'b1;
         end
      end
      if (tag_i == '0) begin
         data_o  = '0;
         ready_o = 1'b1;
      end
   end
endmodule

module phys_reg_file_cdb #(
   parameter int N         = 3,
   parameter int PHYS_REGS = 64,
   parameter int DATA_W    = 32,
   localparam int PHYS_REG_IDX = $clog2(PHYS_REGS)
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic [N-1:0][DATA_W-1:0]            cdb_completing_results_i,
   input  logic [N-1:0][PHYS_REG_IDX-1:0]      cdb_completing_phys_regs_i,
   input  logic [N-1:0]                        cdb_completing_valid_i,
   input  logic [N-1:0]                        alloc_valid_i,
   input  logic [N-1:0][PHYS_REG_IDX-1:0]      alloc_phys_regs_i,
   input  logic [2*N-1:0][PHYS_REG_IDX-1:0]    rd_idx_i,
   output logic [2*N-1:0][DATA_W-1:0]          rd_data_o,
   output logic [2*N-1:0]                      rd_ready_o,
   output logic [PHYS_REGS-1:0]                ready_vec_o
);
   logic [PHYS_REGS-1:0][DATA_W-1:0] data_q, data_d;
   logic [PHYS_REGS-1:0]             ready_q, ready_d;

   always_comb begin
      data_d  = data_q;
      ready_d = ready_q;
      for (int i = 0; i < N; i++) begin
         if (cdb_completing_valid_i[i] && (cdb_completing_phys_regs_i[i] != '0)) begin
            data_d[cdb_completing_phys_regs_i[i]]  = cdb_completing_results_i[i];
            ready_d[cdb_completing_phys_regs_i[i]] = 1'b1;
         end
      end
      // Allocation applied last: it owns the ready bit on a same-tag collision.
      for (int i = 0; i < N; i++) begin
         if (alloc_valid_i[i] && (alloc_phys_regs_i[i] != '0))
            ready_d[alloc_phys_regs_i[i]] = 1'b0;
      end
      data_d[0]  = '0;
      ready_d[0] = 1'b1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         data_q  <= '0;
         ready_q <= '1;
      end else begin
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

   assign ready_vec_o = ready_q;

   for (genvar j = 0; j < 2*N; j++) begin : g_rd
      phys_reg_file_cdb_rd_port #(
         .N(N), .PHYS_REGS(PHYS_REGS), .DATA_W(DATA_W), .IDX_W(PHYS_REG_IDX)
      ) u_rd (
         .tag_i     (rd_idx_i[j]),
         .cdb_res_i (cdb_completing_results_i),
         .cdb_tag_i (cdb_completing_phys_regs_i),
         .cdb_vld_i (cdb_completing_valid_i),
         .data_i    (data_q),
         .ready_i   (ready_q),
         .data_o    (rd_data_o[j]),
         .ready_o   (rd_ready_o[j])
      );
   end

`ifndef SYNTHESIS
   logic dup_tag;
   always_comb begin
      dup_tag = 1'b0;
      for (int i = 0; i < N; i++)
         for (int k = i + 1; k < N; k++)
            if (cdb_completing_valid_i[i] && cdb_completing_valid_i[k] &&
                (cdb_completing_phys_regs_i[i] != '0) &&
                (cdb_completing_phys_regs_i[i] == cdb_completing_phys_regs_i[k]))
               dup_tag = 1'b1;
   end

   // Illegal traffic is tolerated (highest lane wins) but flagged as a warning.
   always @(posedge clock_i)
      if (!reset_i)
         a_dup_tag: assert (!dup_tag) else $warning("duplicate CDB tag in one cycle");
`endif
endmodule

// File: tb/tb_phys_reg_file_cdb.sv
// Scoreboard bench for phys_reg_file_cdb: expected read results are queued when
// the read is driven and compared once the DUT output has settled.

module tb_phys_reg_file_cdb;
   localparam int N  = 3;
   localparam int PR = 64;
   localparam int DW = 32;
   localparam int IW = 6;

   logic                     clk, rst;
   logic [N-1:0][DW-1:0]     cdb_res;
   logic [N-1:0][IW-1:0]     cdb_tag;
   logic [N-1:0]             cdb_vld;
   logic [N-1:0]             al_vld;
   logic [N-1:0][IW-1:0]     al_tag;
   logic [2*N-1:0][IW-1:0]   rd_idx;
   logic [2*N-1:0][DW-1:0]   rd_data;
   logic [2*N-1:0]           rd_ready;
   logic [PR-1:0]            ready_vec;

   typedef struct {
      string          nm;
      int             port;
      logic [DW-1:0]  data;
      logic           rdy;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   phys_reg_file_cdb #(.N(N), .PHYS_REGS(PR), .DATA_W(DW)) dut (
      .clock_i                    (clk),
      .reset_i                    (rst),
      .cdb_completing_results_i   (cdb_res),
      .cdb_completing_phys_regs_i (cdb_tag),
      .cdb_completing_valid_i     (cdb_vld),
      .alloc_valid_i              (al_vld),
      .alloc_phys_regs_i          (al_tag),
      .rd_idx_i                   (rd_idx),
      .rd_data_o                  (rd_data),
      .rd_ready_o                 (rd_ready),
      .ready_vec_o                (ready_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic rd(input string nm, input int port, input int tag,
                     input logic [DW-1:0] d, input logic r);
      exp_t e;
      rd_idx[port] = IW'(tag);
      e.nm = nm; e.port = port; e.data = d; e.rdy = r;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.nm, ".d"}, 64'(rd_data[e.port]), 64'(e.data));
         chk({e.nm, ".r"}, 64'(rd_ready[e.port]), 64'(e.rdy));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cdb_vld = '0;
      al_vld  = '0;
   endtask

   task automatic cdb(input int lane, input int tag, input logic [DW-1:0] v);
      cdb_vld[lane] = 1'b1;
      cdb_tag[lane] = IW'(tag);
      cdb_res[lane] = v;
   endtask

   task automatic alloc(input int lane, input int tag);
      al_vld[lane] = 1'b1;
      al_tag[lane] = IW'(tag);
   endtask

   initial begin
      rst = 1'b1;
      cdb_res = '0; cdb_tag = '0; cdb_vld = '0;
      al_vld = '0; al_tag = '0; rd_idx = '0;

      // Reset values, observed while reset is held
      #12;
      chk("rst_rv", 64'(ready_vec), {64{1'b1}});
      rd("rst_t0", 0, 0, 32'h0, 1'b1);
      rd("rst_t5", 1, 5, 32'h0, 1'b1);
      rd("rst_t63", 2, 63, 32'h0, 1'b1);
      drain();
      @(posedge clk); #1;
      rst = 1'b0;

      // Allocate then complete tag 12
      alloc(0, 12);
      step();
      chk("al12_rv", 64'(ready_vec[12]), 64'd0);
      rd("al12", 0, 12, 32'h0, 1'b0);
      drain();
      cdb(1, 12, 32'hDEADBEEF);
      rd("byp12", 1, 12, 32'hDEADBEEF, 1'b1);
      drain();
      step();
      chk("wr12_rv", 64'(ready_vec[12]), 64'd1);
      rd("wr12", 0, 12, 32'hDEADBEEF, 1'b1);
      drain();

      // Full-width CDB on tags 3, 7, 9
      alloc(0, 3); alloc(1, 7); alloc(2, 9);
      step();
      chk("al379_rv", 64'({ready_vec[9], ready_vec[7], ready_vec[3]}), 64'd0);
      cdb(0, 3, 32'h3333_0003); cdb(1, 7, 32'h7777_0007); cdb(2, 9, 32'h9999_0009);
      step();
      chk("fw_rv", 64'({ready_vec[9], ready_vec[7], ready_vec[3]}), 64'b111);
      rd("fw3", 0, 3, 32'h3333_0003, 1'b1);
      rd("fw7", 1, 7, 32'h7777_0007, 1'b1);
      rd("fw9", 2, 9, 32'h9999_0009, 1'b1);
      drain();

      // Full-width again with tag 0 on lane 0
      cdb(0, 0, 32'hFFFF_FFFF); cdb(1, 7, 32'h0000_A007); cdb(2, 9, 32'h0000_B009);
      rd("z_byp0", 3, 0, 32'h0, 1'b1);
      drain();
      step();
      rd("z_t0", 0, 0, 32'h0, 1'b1);
      rd("z_t7", 1, 7, 32'h0000_A007, 1'b1);
      rd("z_t9", 2, 9, 32'h0000_B009, 1'b1);
      rd("z_t3", 3, 3, 32'h3333_0003, 1'b1);
      drain();
      chk("z_rv0", 64'(ready_vec[0]), 64'd1);

      // Same tag allocated and completed in one cycle
      alloc(2, 20); cdb(0, 20, 32'h55);
      rd("col_byp", 4, 20, 32'h55, 1'b1);
      drain();
      step();
      rd("col", 4, 20, 32'h55, 1'b0);
      drain();
      chk("col_rv", 64'(ready_vec[20]), 64'd0);

      // Duplicate CDB tag: highest lane wins
      cdb(0, 30, 32'h1); cdb(2, 30, 32'h2);
      rd("dup_byp", 5, 30, 32'h2, 1'b1);
      drain();
      step();
      rd("dup", 5, 30, 32'h2, 1'b1);
      drain();

      // Async reset mid-cycle while tag 40 is not ready
      alloc(1, 40); cdb(2, 40, 32'hABCD);
      step();
      chk("pre_rv40", 64'(ready_vec[40]), 64'd0);
      rd("pre40", 0, 40, 32'hABCD, 1'b0);
      drain();
      #2;
      rst = 1'b1;
      rd("ar40", 0, 40, 32'h0, 1'b1);
      rd("ar12", 1, 12, 32'h0, 1'b1);
      drain();
      chk("ar_rv40", 64'(ready_vec[40]), 64'd1);
      chk("ar_rv", 64'(ready_vec), {64{1'b1}});
      @(negedge clk);
      rst = 1'b0;
      alloc(0, 44);
      drain();
      chk("rel_hold44", 64'(ready_vec[44]), 64'd1);
      @(posedge clk); #1;
      al_vld = '0;
      chk("rel_al44", 64'(ready_vec[44]), 64'd0);

      // Post-reset write still works
      cdb(2, 5, 32'h0BAD_F00D);
      step();
      rd("post5", 2, 5, 32'h0BAD_F00D, 1'b1);
      rd("post20", 3, 20, 32'h0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
